ultrasonic_ranger: RTL and testbench

Upstream feeder for the object-detection distance stage. It drives an HC-SR04-style ultrasonic sensor: it fires a trigger pulse, times the returning echo pulse, and converts the echo width to a 23-bit distance in micrometres (0..4 m range). It produces distance and time_out as held registered levels, plus a one-cycle valid strobe per measurement. The detection stage samples these every cycle.

---
 rtl/ultrasonic_ranger.sv | 108 ++++++++++
 tb/tb_ultrasonic_ranger.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04 trigger/echo timer producing distance in micrometres; define RANGER_MEDIAN_EN for a 3-sample median filter
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES     = 500,
  parameter int ECHO_WAIT_MAX   = 50_000,
  parameter int TIMEOUT_CYCLES  = 1_166_000,
  parameter int HOLDOFF_CYCLES  = 3_000_000,
  parameter int UM_PER_CYCLE_Q8 = 878
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        echo,
  output logic        trig,
  output logic [22:0] distance,
  output logic        time_out,
  output logic        valid
);
  localparam int CW = $clog2(TRIG_CYCLES + ECHO_WAIT_MAX + HOLDOFF_CYCLES + 1);
  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_DONE, S_HOLD} state_t;
  state_t        r_state, w_next;
  logic          r_echo_m, r_echo_s;
  logic [CW-1:0] r_cnt;
  logic [20:0]   r_echo_cnt;
  logic          w_good, w_fail;
  logic [31:0]   w_prod;
  logic [23:0]   w_q;
  logic [22:0]   w_raw, w_dist;
  // two-flop synchroniser for the asynchronous echo input
  always_ff @(posedge clk or negedge rst)
    if (!rst) {r_echo_s, r_echo_m} <= '0;
    else      {r_echo_s, r_echo_m} <= {r_echo_m, echo};
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  // next state; w_good/w_fail mark the cycle a measurement resolves
  always_comb begin
    w_next = r_state;
    w_good = 1'b0;
    w_fail = 1'b0;
    case (r_state)
      S_IDLE: w_next = enable ? S_TRIG : S_IDLE;
      S_TRIG: w_next = (r_cnt == CW'(TRIG_CYCLES - 1)) ? S_WAIT : S_TRIG;
      S_WAIT: begin
        w_fail = !r_echo_s && (r_cnt == CW'(ECHO_WAIT_MAX - 1));
        w_next = r_echo_s ? S_MEAS : w_fail ? S_DONE : S_WAIT;
      end
      S_MEAS: begin
        w_good = !r_echo_s;
        w_fail = r_echo_s && (r_echo_cnt == 21'(TIMEOUT_CYCLES - 1));
        w_next = (w_good || w_fail) ? S_DONE : S_MEAS;
      end
      S_DONE: w_next = S_HOLD;
      S_HOLD: w_next = (r_cnt != CW'(HOLDOFF_CYCLES - 1)) ? S_HOLD :
                       !enable ? S_IDLE : r_echo_s ? S_HOLD : S_TRIG;
      default: w_next = S_IDLE;
    endcase
  end
  // phase counter restarts on every state change and saturates at the end of holdoff; echo counter runs only in MEAS
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt      <= '0;
      r_echo_cnt <= '0;
    end else begin
      r_cnt      <= (w_next != r_state || r_state inside {S_IDLE, S_MEAS}) ? '0 :
                    (r_state == S_HOLD && r_cnt == CW'(HOLDOFF_CYCLES - 1)) ? r_cnt : r_cnt + 1'b1;
      r_echo_cnt <= (r_state == S_MEAS) ? r_echo_cnt + 21'(r_echo_s) : '0;
    end
  // the rise cycle seen in WAIT is part of the echo width, hence the +1
  assign w_prod = 32'(r_echo_cnt + 21'd1) * 32'(UM_PER_CYCLE_Q8);
  assign w_q    = 24'(w_prod >> 8);
  assign w_raw  = w_q[23] ? '1 : w_q[22:0];
`ifdef RANGER_MEDIAN_EN
  logic [22:0] r_win0, r_win1, w_lo, w_hi;
  logic [1:0]  r_wcnt;
  assign w_lo   = (w_raw < r_win0) ? w_raw : r_win0;
  assign w_hi   = (w_raw < r_win0) ? r_win0 : w_raw;
  assign w_dist = (r_wcnt != 2'd2) ? w_raw : (r_win1 < w_lo) ? w_lo : (r_win1 > w_hi) ? w_hi : r_win1;
  // window of the two previous good raw distances; the new one completes the triple
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_win0 <= '0;
      r_win1 <= '0;
      r_wcnt <= '0;
    end else if (w_good) begin
      r_win1 <= r_win0;
      r_win0 <= w_raw;
      r_wcnt <= (r_wcnt == 2'd2) ? r_wcnt : r_wcnt + 2'd1;
    end
`else
  assign w_dist = w_raw;
`endif
  // registered outputs; distance/time_out update only when entering DONE, alongside valid
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      trig     <= 1'b0;
      valid    <= 1'b0;
      distance <= '0;
      time_out <= 1'b0;
    end else begin
      trig  <= (w_next == S_TRIG);
      valid <= (w_next == S_DONE);
      if (w_good) begin
        distance <= w_dist;
        time_out <= 1'b0;
      end else if (w_fail) time_out <= 1'b1;
    end
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: randomized echo timing checked against a cycle-arithmetic reference model
module tb_ultrasonic_ranger;
  localparam int TRIG = 4, WAITM = 200, TMO = 1000, HOLD = 50, UMQ = 878;
  logic        clk = 1'b0, rst = 1'b0, enable = 1'b0, echo = 1'b0;
  logic        trig, time_out, valid;
  logic [22:0] distance;
  int n_chk = 0, n_pass = 0, cyc = 0, er = 0, ef = 0;
  int exp_dist = 0, next_trig = 0, start_ref = -1;
  bit exp_to = 1'b0;
`ifdef RANGER_MEDIAN_EN
  int win[$];
`endif

  ultrasonic_ranger #(
    .TRIG_CYCLES(TRIG), .ECHO_WAIT_MAX(WAITM), .TIMEOUT_CYCLES(TMO),
    .HOLDOFF_CYCLES(HOLD), .UM_PER_CYCLE_Q8(UMQ)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .echo(echo),
    .trig(trig), .distance(distance), .time_out(time_out), .valid(valid)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    echo = (cyc >= er && cyc < ef);
  endtask

  function automatic int conv(input int w);
    longint p;
    p = longint'(w) * UMQ / 256;
    return (p > 64'h7FFFFF) ? 'h7FFFFF : int'(p);
  endfunction

  function automatic int filt(input int raw);
`ifdef RANGER_MEDIAN_EN
    int a, b, c, mx, mn;
    win.push_back(raw);
    if (win.size() > 3) void'(win.pop_front());
    if (win.size() < 3) return raw;
    a = win[0]; b = win[1]; c = win[2];
    mx = (a > b) ? a : b; mx = (mx > c) ? mx : c;
    mn = (a < b) ? a : b; mn = (mn < c) ? mn : c;
    return a + b + c - mx - mn;
`else
    return raw;
`endif
  endfunction

  // one measurement: echo rises d cycles after trig falls and lasts w cycles (w=0: no echo)
  task automatic meas(input int d, input int w, input bit drop);
    int n, k, exp_lat;
    bit fail;
    n = 0;
    while (!trig && n < 5000) begin step(); n++; end
    if (!trig) begin
      check("trig_start", 0, 1);
      return;
    end
    if (start_ref >= 0) begin
      check("trig_delay", cyc - start_ref, 1);
      start_ref = -1;
    end else check("trig_gap", cyc, next_trig);
    check("dist_hold", distance, exp_dist);
    check("to_hold", time_out, exp_to);
    n = 0;
    while (trig && n < 100) begin step(); n++; end
    check("trig_len", n, TRIG);
    k = cyc;
    if (drop) enable = 1'b0;
    if (w > 0) begin
      er = k + d;
      ef = k + d + w;
    end
    echo = (cyc >= er && cyc < ef);
    fail = (w == 0) || (w > TMO);
    exp_lat = (w == 0) ? WAITM : d + 3 + ((w > TMO) ? TMO : w);
    n = 0;
    while (!valid && n < 3000) begin step(); n++; end
    check("valid_lat", cyc - k, exp_lat);
    if (!fail) exp_dist = filt(conv(w));
    exp_to = fail;
    check("distance", distance, exp_dist);
    check("time_out", time_out, exp_to);
    next_trig = (cyc + HOLD + 1 > ef + 3) ? cyc + HOLD + 1 : ef + 3;
    step();
    check("valid_pulse", valid, 0);
  endtask

  initial begin
    int n;
    repeat (3) step();
    check("rst_trig", trig, 0);
    check("rst_valid", valid, 0);
    check("rst_dist", distance, 0);
    check("rst_to", time_out, 0);
    rst = 1'b1;
    step();
    enable = 1'b1;
    start_ref = cyc;
    meas(20, 100, 0);
    meas(0, 0, 0);
    meas(5, 300, 0);
    meas(197, 200, 0);
    meas(10, 1500, 0);
    meas(3, TMO, 0);
    meas(3, TMO + 1, 0);
    meas(0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      int kind, d, w;
      kind = $urandom_range(0, 9);
      d = $urandom_range(0, 150);
      w = (kind == 0) ? 0 : (kind == 1) ? $urandom_range(TMO + 1, TMO + 400) : $urandom_range(1, TMO);
      meas(d, w, 0);
    end
    meas(20, 100, 0);
    n = 0;
    while (!trig && n < 5000) begin step(); n++; end
    n = 0;
    while (trig && n < 100) begin step(); n++; end
    er = cyc + 10;
    ef = cyc + 610;
    repeat (100) step();
    #2 rst = 1'b0;
    #1;
    check("arst_trig", trig, 0);
    check("arst_valid", valid, 0);
    check("arst_to", time_out, 0);
    check("arst_dist", distance, 0);
    exp_dist = 0;
    exp_to = 1'b0;
`ifdef RANGER_MEDIAN_EN
    win.delete();
`endif
    er = 0;
    ef = 0;
    echo = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("restart_trig", trig, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_trig_drop", trig, 0);
    step();
    rst = 1'b1;
    start_ref = cyc;
    meas(15, 250, 0);
    meas(8, 400, 1);
    n = 0;
    repeat (300) begin
      step();
      if (trig) n++;
    end
    check("parked", n, 0);
    enable = 1'b1;
    start_ref = cyc;
    meas(0, 50, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
